fifo_rd_packer: RTL and testbench

Read-side consumer of the async FIFO, clocked in the read domain. Pops 8-bit bytes through the FIFO's `rd`/`empty`/`data_out` port, accounting for the FIFO's one-cycle registered read latency. Packs `OUT_BYTES` consecutive bytes little-endian into one word presented on a valid/ready stream. A `flush` request emits a trailing partial word with a byte-keep mask.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_rd_packer.sv | 105 ++++++++++
 tb/tb_fifo_rd_packer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FIFO read-side packer
// Purpose: byte width, default output word size and the byte-keep mask helper.
// Ports: none (package).
package fifo_pkg;

  localparam int BYTE_W        = 8;
  localparam int OUT_BYTES_DEF = 4;
  localparam int MAX_OUT_BYTES = 8;

  // Mask with the low 'cnt' bits set; callers truncate to their word size.
  function automatic logic [MAX_OUT_BYTES-1:0] keep_mask(input int unsigned cnt);
    logic [MAX_OUT_BYTES:0] m;
    m = ((MAX_OUT_BYTES + 1)'(1) << cnt) - (MAX_OUT_BYTES + 1)'(1);
    return m[MAX_OUT_BYTES-1:0];
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops bytes from the async FIFO read port and packs them into words
// Purpose: read-domain consumer that packs OUT_BYTES bytes little-endian into one
//          valid/ready word; a flush request emits a trailing partial word with keep mask.
// Ports:
//   rd_clk      read-domain clock
//   rst         synchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after a pop
//   fifo_rd     FIFO pop strobe
//   flush       one-cycle request to emit any partial word
//   out_data    packed word, byte 0 = first popped byte
//   out_keep    per-byte valid mask
//   out_valid   output word valid
//   out_ready   downstream accept
//   flush_busy  flush in progress
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int OUT_BYTES = OUT_BYTES_DEF,
  parameter int CNT_W     = $clog2(OUT_BYTES + 1)
) (
  input  logic                        rd_clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  input  logic [BYTE_W-1:0]           fifo_data,
  output logic                        fifo_rd,
  input  logic                        flush,
  output logic [BYTE_W*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]        out_keep,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        flush_busy
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(OUT_BYTES);

  logic [CNT_W-1:0]  cnt;
  logic              inflight;
  logic              flush_pend;
  logic [BYTE_W-1:0] acc [OUT_BYTES];

  logic              full;
  logic              load;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  wr_idx;

  always_comb begin
    full   = (cnt == FULL);
    // Bytes held plus the byte arriving this cycle; never exceeds OUT_BYTES.
    occ    = cnt + CNT_W'(inflight);
    load   = (full || (flush_pend && !inflight && cnt != '0)) && (!out_valid || out_ready);
    // A full accumulator that empties this cycle frees room for one more pop,
    // which is what sustains OUT_BYTES bytes per OUT_BYTES+1 cycles.
    fifo_rd = !rst && !fifo_empty && !flush_pend && ((occ < FULL) || (full && load));
    // A byte landing in the same cycle as a load starts the next word.
    wr_idx = load ? '0 : cnt;
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      cnt        <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
    end else begin
      if (load) begin
        for (int i = 0; i < OUT_BYTES; i++) begin
          out_data[i*BYTE_W +: BYTE_W] <= (CNT_W'(i) < cnt) ? acc[i] : '0;
        end
        out_keep  <= OUT_BYTES'(keep_mask(32'(cnt)));
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      for (int i = 0; i < OUT_BYTES; i++) begin
        if (inflight && wr_idx == CNT_W'(i)) begin
          acc[i] <= fifo_data;
        end
      end

      if (load) begin
        cnt <= CNT_W'(inflight);
      end else if (inflight) begin
        cnt <= cnt + CNT_W'(1);
      end

      inflight <= fifo_rd;

      // A second flush while one is pending has no effect.
      if (flush_pend) begin
        if (load || (!inflight && cnt == '0)) begin
          flush_pend <= 1'b0;
        end
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  assign flush_busy = flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - scoreboard testbench for fifo_rd_packer
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int OB = 4;
  localparam int DW = 8 * OB;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [OB-1:0] keep;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [7:0]    fifo_data = 8'h00;
  logic          fifo_rd;
  logic          flush = 1'b0;
  logic [DW-1:0] out_data;
  logic [OB-1:0] out_keep;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush_busy;

  always #5 clk = ~clk;

  fifo_rd_packer #(.OUT_BYTES(OB)) dut (
    .rd_clk     (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_busy (flush_busy)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] fifo_q [$];
  logic [7:0] grp [$];
  word_t      exp_q [$];
  int         gate_mode = 0;
  logic       gate = 1'b0;
  logic       s_rd = 1'b0;
  logic       s_rst = 1'b1;
  logic       s_flush = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [OB-1:0] prev_keep = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bytes popped since the last flush/reset; every OB bytes form a word,
  // a flush closes whatever is left as a partial word.
  task automatic close_group();
    word_t w;
    w = '0;
    for (int i = 0; i < grp.size(); i++) begin
      w.data[i*8 +: 8] = grp[i];
      w.keep[i]        = 1'b1;
    end
    exp_q.push_back(w);
    grp.delete();
  endtask

  // FIFO model plus reference bookkeeping, applied just after each active edge.
  always @(posedge clk) begin
    #1;
    if (s_rst) begin
      fifo_q.delete();
      grp.delete();
      exp_q.delete();
      fifo_data = 8'h00;
    end else begin
      if (s_rd && fifo_q.size() > 0) begin
        fifo_data = fifo_q.pop_front();
        grp.push_back(fifo_data);
        if (grp.size() == OB) close_group();
      end else begin
        fifo_data = 8'($urandom);
      end
      if (s_flush && grp.size() > 0) close_group();
    end
    case (gate_mode)
      1:       gate = ~gate;
      2:       gate = 1'($urandom);
      default: gate = 1'b0;
    endcase
    fifo_empty = gate || (fifo_q.size() == 0);
  end

  // Monitor: samples mid-cycle, pops the scoreboard on every accepted word.
  always @(negedge clk) begin : mon
    word_t w;
    s_rd    = fifo_rd;
    s_rst   = rst;
    s_flush = flush;
    if (!rst) begin
      if (fifo_rd) chk("rd_while_empty", 64'(fifo_empty), 64'(0));
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_keep", 64'(out_keep), 64'(prev_keep));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h, expected no word", out_data, out_keep);
        end else begin
          w = exp_q.pop_front();
          chk("word_data", 64'(out_data), 64'(w.data));
          chk("word_keep", 64'(out_keep), 64'(w.keep));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || out_valid) && c < 400) begin
      step();
      c++;
    end
    chk({name, "_timeout"}, 64'(c >= 400), 64'(0));
  endtask

  task automatic pulse_flush();
    int c;
    c = 0;
    while (flush_busy && c < 100) begin
      step();
      c++;
    end
    chk("flush_idle_timeout", 64'(c >= 100), 64'(0));
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin : stim
    int first_rd, first_ov, npop, found;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_keep", 64'(out_keep), 64'(0));
    chk("rst_flush_busy", 64'(flush_busy), 64'(0));
    step();

    // Two full words, plus first-word latency
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    first_rd = -1;
    first_ov = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_rd && first_rd < 0) first_rd = c;
      if (out_valid && first_ov < 0) first_ov = c;
    end
    // first_rd+1 is the edge that takes the pop; out_valid is set 5 edges later.
    chk("pop_edge_to_valid", 64'(first_ov - first_rd - 1), 64'(5));
    step();
    wait_idle("two_words");

    // Backpressure: only two words' worth of bytes may be taken
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) fifo_q.push_back(8'(i));
    npop = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fifo_rd) npop++;
    end
    chk("stall_pop_count", 64'(npop), 64'(8));
    chk("stall_rd_low", 64'(fifo_rd), 64'(0));
    chk("stall_word", 64'(out_data), 64'(32'h04030201));
    chk("stall_word_keep", 64'(out_keep), 64'(4'hF));
    step();
    out_ready = 1'b1;
    wait_idle("backpressure");

    // Partial word on flush
    fifo_q.push_back(8'hAA);
    fifo_q.push_back(8'hBB);
    fifo_q.push_back(8'hCC);
    repeat (6) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_high", 64'(flush_busy), 64'(1));
    step();
    @(negedge clk);
    chk("flush_busy_done", 64'(flush_busy), 64'(0));
    chk("partial_data", 64'(out_data), 64'(32'h00CCBBAA));
    chk("partial_keep", 64'(out_keep), 64'(4'b0111));
    step();
    wait_idle("partial");

    // Flush with nothing held: one-cycle busy pulse, no word
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("empty_flush_busy", 64'(flush_busy), 64'(1));
    step();
    @(negedge clk);
    chk("empty_flush_busy_clr", 64'(flush_busy), 64'(0));
    chk("empty_flush_no_word", 64'(out_valid), 64'(0));
    step();

    // Flush while a pop is in flight: that byte belongs to the partial word
    fifo_q.push_back(8'h5A);
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (fifo_rd) found = 1;
    end
    chk("inflight_pop_seen", 64'(found), 64'(1));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle("inflight_flush");

    // Empty flag toggling every cycle
    gate_mode = 1;
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'($urandom));
    wait_idle("toggle_empty");
    gate_mode = 0;
    step();

    // Reset mid-word (two bytes held, one in flight)
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'h61 + 8'(i));
    npop = 0;
    for (int c = 0; c < 20 && npop < 3; c++) begin
      @(negedge clk);
      if (fifo_rd) npop++;
    end
    chk("pre_reset_pops", 64'(npop), 64'(3));
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_fifo_empty_low", 64'(fifo_empty), 64'(0));
    chk("reset_fifo_rd", 64'(fifo_rd), 64'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    chk("post_rst_data", 64'(out_data), 64'(0));
    chk("post_rst_keep", 64'(out_keep), 64'(0));
    chk("post_rst_busy", 64'(flush_busy), 64'(0));
    step();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h91 + 8'(i));
    wait_idle("after_reset");

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0) && !flush_busy;
      if ($urandom_range(0, 99) == 0) gate_mode = $urandom_range(0, 2);
      step();
    end
    flush = 1'b0;
    gate_mode = 0;
    out_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (fifo_q.size() == 0) found = 1;
      step();
    end
    chk("random_fifo_drain", 64'(found), 64'(1));
    repeat (4) step();
    pulse_flush();
    wait_idle("random");

    repeat (5) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

endmodule
